rpsc_annunciator_ctrl: RTL and testbench
========================================

// Module: rpsc_annunciator_ctrl
// PURPOSE
//  Sequences the N_CH trip-latch/lamp channels of an RPSC card (per channel: latch output + lamp).
//  Qualifies raw trip inputs, latches them, and drives lamps through a flash/ack/reset sequence.
//  Also drives the horn and reports the first-out channel.
//  Sits between field trip inputs / operator pushbuttons and the card's latch and lamp outputs.
// PARAMETERS
//  N_CH       8   number of trip channels
//  FILT_CYC   4   consecutive synced-high cycles required to qualify a trip (>=1)
//  FLASH_DIV  25_000_000  clk cycles per lamp flash half-period (>=2)
//  LT_STEP    50_000_000  clk cycles per lamp-test step (only with RPSC_LAMP_TEST_EN)
// PORTS
//  clk            in   1       system clock
//  reset_n        in   1       synchronous, active-low reset
//  trip_in        in   N_CH    raw asynchronous trip inputs; active high
//  ack_btn        in   1       operator acknowledge; async, level
//  rst_btn        in   1       operator latch reset; async, level
//  lamp_test_btn  in   1       lamp-test request; port exists only with RPSC_LAMP_TEST_EN
//  trip_latch_out out  N_CH    latched trip per channel
//  lamp_out       out  N_CH    lamp drive per channel
//  horn_out       out  1       audible alarm
//  first_vld      out  1       first-out index valid
//  first_idx      out  $clog2(N_CH)  index of first channel to trip
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk edge): every channel goes to NORMAL; counters, synchronizers and
//    flash phase go to 0; all outputs go to 0. The same applies to a reset issued mid-sequence.
//  - Input qualification: each input goes through a 2-FF synchronizer and then a per-channel run counter.
//    - trip_q is registered. It sets when the synced bit has been 1 for FILT_CYC consecutive edges.
//    - It clears on the first synced 0.
//    - trip_latch_out rises exactly FILT_CYC+3 edges after a stable trip_in rise.
//  - Buttons: each button goes through a 2-FF synchronizer and a rising-edge detector, giving one pulse per press.
//  - Per-channel FSM:
//    - NORMAL -> ALARM on trip_q.
//    - ALARM -> ACKED on ack pulse.
//    - ACKED -> NORMAL on rst pulse, but only when trip_q=0. A rst pulse with trip_q=1 is ignored.
//    - ALARM ignores rst.
//    - ACKED ignores a re-asserted trip.
//    - An ack and a rst pulse in the same cycle while in ALARM: only the ack takes effect.
//  - Outputs, all registered and updated on the same edge as the state:
//    - trip_latch_out = (state != NORMAL).
//    - lamp_out: 0 in NORMAL, flash_phase in ALARM, 1 in ACKED.
//    - horn_out = OR over channels of (state == ALARM).
//  - Flash: a free-running counter counts 0..FLASH_DIV-1 and toggles flash_phase on wrap. flash_phase is 0 after reset.
//  - First-out:
//    - Capture occurs when no channel is out of NORMAL and one or more channels enter ALARM in the same cycle.
//    - On capture, first_idx = lowest such index and first_vld goes to 1.
//    - Later trips do not change it.
//    - first_vld and first_idx clear to 0 in the cycle after all channels are back in NORMAL.
// CONFIGURATION
//  RPSC_LAMP_TEST_EN defined:
//    - Trigger: a lamp_test_btn pulse while no channel is in ALARM and no test is running starts a test.
//    - Sequence: lamp k alone is forced on for LT_STEP cycles, k = 0..N_CH-1.
//      Then all lamps are forced on for LT_STEP cycles, then normal lamp drive resumes.
//    - During the test, latch, horn and first-out logic run unaffected.
//    - Any channel entering ALARM aborts the test; normal lamp_out is shown from the next edge.
//  RPSC_LAMP_TEST_EN undefined: lamp_test_btn port, step counter and test FSM are absent.
// STRUCTURE
//  - Package rpsc_ann_pkg holds:
//    - typedef enum logic [1:0] {ANN_NORMAL, ANN_ALARM, ANN_ACKED} ann_state_t;
//    - the lamp-test state enum.
//  - Sub-module rpsc_ann_channel: synchronizer + filter + FSM + lamp mux for one channel.
//    It is instantiated N_CH times in a generate loop.
//  - The top level holds the flash counter, button edge detectors, first-out logic, horn OR and lamp test.
// TESTING (bench: N_CH=8, FILT_CYC=4, FLASH_DIV=8, LT_STEP=16)
//  1 Reset with trip_in=8'hFF held -> all outputs 0 during reset. After release, trip_latch_out=FF
//    at edge 7, horn_out=1, first_idx=0, first_vld=1.
//  2 trip_in[3] glitch high for 3 cycles -> no latch. Held 4+ cycles -> trip_latch_out[3]=1 at edge 7.
//    Then lamp_out[3] toggles every 8 cycles and horn_out=1.
//  3 Ack then reset sequence on ch3, with trip still active:
//    - ack pulse -> lamp_out[3]=1 steady, horn_out=0.
//    - rst while trip_in[3]=1 -> no change.
//    - drop trip, then rst -> trip_latch_out[3]=0, first_vld=0 next cycle.
//  4 trip_in[5] and trip_in[2] rise in the same cycle -> first_idx=2. A later trip_in[0] leaves first_idx=2.
//    Simultaneous ack+rst in ALARM -> ACKED only.
//  5 Reset asserted for 1 cycle while ch1 is ACKED and ch6 is in ALARM -> all outputs 0 on the next edge.
//  6 [RPSC_LAMP_TEST_EN] Normal test: lamp_test_btn pulse -> lamp_out walks 01,02,..,80 at 16 cycles each,
//    then FF for 16 cycles, then 00.
//    Abort: trip_in[4] asserted during the walk -> test aborts, lamp_out shows only the flashing ch4.

Source files
------------

// File: rtl/rpsc_ann_pkg.sv
// Shared types for the RPSC annunciator: per-channel state and lamp-test sequencer state.
// No logic; pure type definitions.
// Imported by the channel sub-module and the top level.
package rpsc_ann_pkg;

  typedef enum logic [1:0] {
    ANN_NORMAL,
    ANN_ALARM,
    ANN_ACKED
  } ann_state_t;

  typedef enum logic [1:0] {
    LT_IDLE,
    LT_WALK,
    LT_ALL
  } lt_state_t;

endpackage

// File: rtl/rpsc_ann_channel.sv
// One trip channel: 2-FF sync, run-length filter, alarm/ack/reset FSM, latch and lamp drive.
// Latency: trip_latch rises FILT_CYC+3 edges after a stable trip_raw rise.
// No backpressure; ack/rst are single-cycle pulses from the top level.
module rpsc_ann_channel
  import rpsc_ann_pkg::*;
#(
  parameter int FILT_CYC = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trip_raw,
  input  logic ack,
  input  logic rst,
  input  logic flash_phase,
  output logic trip_latch,
  output logic lamp,
  output logic enter_alarm,
  output logic alarm_next,
  output logic active
);

  localparam int CNT_W = $clog2(FILT_CYC + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] run_cnt;
  logic             trip_q;
  ann_state_t       state;
  ann_state_t       state_nxt;

  // Synchronize the raw trip and qualify it with a saturating run counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      run_cnt <= '0;
      trip_q  <= 1'b0;
    end else begin
      sync1 <= trip_raw;
      sync2 <= sync1;
      if (sync2) begin
        if (run_cnt < CNT_W'(FILT_CYC - 1)) begin
          run_cnt <= run_cnt + 1'b1;
        end
        // Counter value is the number of earlier consecutive highs; this edge makes one more.
        trip_q <= (run_cnt >= CNT_W'(FILT_CYC - 1));
      end else begin
        run_cnt <= '0;
        trip_q  <= 1'b0;
      end
    end
  end

  // Channel state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ANN_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; ack has priority in ALARM, rst only clears a dropped trip in ACKED.
  always_comb begin
    state_nxt = state;
    case (state)
      ANN_NORMAL: if (trip_q)          state_nxt = ANN_ALARM;
      ANN_ALARM:  if (ack)             state_nxt = ANN_ACKED;
      ANN_ACKED:  if (rst && !trip_q)  state_nxt = ANN_NORMAL;
      default:                         state_nxt = ANN_NORMAL;
    endcase
  end

  // Latch and lamp are registered from the next state so they move on the same edge as state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      trip_latch <= 1'b0;
      lamp       <= 1'b0;
    end else begin
      trip_latch <= (state_nxt != ANN_NORMAL);
      case (state_nxt)
        ANN_ALARM: lamp <= flash_phase;
        ANN_ACKED: lamp <= 1'b1;
        default:   lamp <= 1'b0;
      endcase
    end
  end

  assign enter_alarm = (state == ANN_NORMAL) && (state_nxt == ANN_ALARM);
  assign alarm_next  = (state_nxt == ANN_ALARM);
  assign active      = (state != ANN_NORMAL);

endmodule

// File: rtl/rpsc_annunciator_ctrl.sv
// RPSC annunciator: N_CH trip channels, flash timebase, button pulses, horn, first-out, optional lamp test.
// Latency: latch/lamp/horn/first-out registered on the state edge; buttons act 3 edges after a press.
// No backpressure. Optional lamp test is built only when RPSC_LAMP_TEST_EN is defined.
module rpsc_annunciator_ctrl
  import rpsc_ann_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int FILT_CYC  = 4,
  parameter int FLASH_DIV = 25_000_000
`ifdef RPSC_LAMP_TEST_EN
  ,
  parameter int LT_STEP   = 50_000_000
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         trip_in,
  input  logic                    ack_btn,
  input  logic                    rst_btn,
`ifdef RPSC_LAMP_TEST_EN
  input  logic                    lamp_test_btn,
`endif
  output logic [N_CH-1:0]         trip_latch_out,
  output logic [N_CH-1:0]         lamp_out,
  output logic                    horn_out,
  output logic                    first_vld,
  output logic [$clog2(N_CH)-1:0] first_idx
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int FL_W  = $clog2(FLASH_DIV);
`ifdef RPSC_LAMP_TEST_EN
  localparam int NB    = 3;
`else
  localparam int NB    = 2;
`endif

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    btn_s1;
  logic [NB-1:0]    btn_s2;
  logic [NB-1:0]    btn_s3;
  logic [NB-1:0]    btn_pulse;
  logic [FL_W-1:0]  flash_cnt;
  logic             flash_phase;
  logic [N_CH-1:0]  ch_lamp;
  logic [N_CH-1:0]  enter;
  logic [N_CH-1:0]  alarm_nxt;
  logic [N_CH-1:0]  active;
  logic [IDX_W-1:0] low_idx;
  logic             all_normal;

`ifdef RPSC_LAMP_TEST_EN
  assign btn_raw = {lamp_test_btn, rst_btn, ack_btn};
`else
  assign btn_raw = {rst_btn, ack_btn};
`endif

  // Synchronize operator buttons and keep one extra stage for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_s3 <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign btn_pulse = btn_s2 & ~btn_s3;

  // Free-running flash timebase; phase flips every FLASH_DIV cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (flash_cnt == FL_W'(FLASH_DIV - 1)) begin
      flash_cnt   <= '0;
      flash_phase <= ~flash_phase;
    end else begin
      flash_cnt <= flash_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rpsc_ann_channel #(
      .FILT_CYC (FILT_CYC)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .trip_raw    (trip_in[g]),
      .ack         (btn_pulse[0]),
      .rst         (btn_pulse[1]),
      .flash_phase (flash_phase),
      .trip_latch  (trip_latch_out[g]),
      .lamp        (ch_lamp[g]),
      .enter_alarm (enter[g]),
      .alarm_next  (alarm_nxt[g]),
      .active      (active[g])
    );
  end

  // Horn follows the OR of channels that will be in ALARM after this edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      horn_out <= 1'b0;
    end else begin
      horn_out <= |alarm_nxt;
    end
  end

  // Lowest-numbered channel entering ALARM this cycle.
  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (enter[i]) low_idx = IDX_W'(i);
    end
  end

  assign all_normal = ~|active;

  // First-out: capture only from an all-quiet card; clears the cycle after all return to NORMAL.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first_vld <= 1'b0;
      first_idx <= '0;
    end else if (all_normal && |enter) begin
      first_vld <= 1'b1;
      first_idx <= low_idx;
    end else if (all_normal) begin
      first_vld <= 1'b0;
      first_idx <= '0;
    end
  end

`ifdef RPSC_LAMP_TEST_EN
  localparam int LT_W = $clog2(LT_STEP);

  lt_state_t        lt_state;
  lt_state_t        lt_nxt;
  logic [LT_W-1:0]  lt_cnt;
  logic [LT_W-1:0]  lt_cnt_nxt;
  logic [IDX_W-1:0] lt_idx;
  logic [IDX_W-1:0] lt_idx_nxt;
  logic [N_CH-1:0]  lt_pat;
  logic [N_CH-1:0]  lt_pat_nxt;
  logic             step_done;

  assign step_done = (lt_cnt == LT_W'(LT_STEP - 1));

  // Lamp-test state, step counter and forced pattern registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lt_state <= LT_IDLE;
      lt_cnt   <= '0;
      lt_idx   <= '0;
      lt_pat   <= '0;
    end else begin
      lt_state <= lt_nxt;
      lt_cnt   <= lt_cnt_nxt;
      lt_idx   <= lt_idx_nxt;
      lt_pat   <= lt_pat_nxt;
    end
  end

  // Walk one lamp at a time, then all lamps; any new alarm aborts. horn_out mirrors current ALARMs.
  always_comb begin
    lt_nxt     = lt_state;
    lt_cnt_nxt = step_done ? '0 : lt_cnt + 1'b1;
    lt_idx_nxt = lt_idx;
    case (lt_state)
      LT_IDLE: begin
        lt_cnt_nxt = '0;
        if (btn_pulse[2] && !horn_out) lt_nxt = LT_WALK;
      end
      LT_WALK: begin
        if (step_done) begin
          if (lt_idx == IDX_W'(N_CH - 1)) lt_nxt = LT_ALL;
          else                            lt_idx_nxt = lt_idx + 1'b1;
        end
      end
      LT_ALL:  if (step_done) lt_nxt = LT_IDLE;
      default: lt_nxt = LT_IDLE;
    endcase
    if (|enter) lt_nxt = LT_IDLE;
    if (lt_nxt == LT_IDLE) begin
      lt_cnt_nxt = '0;
      lt_idx_nxt = '0;
    end
    case (lt_nxt)
      LT_WALK: lt_pat_nxt = N_CH'(1) << lt_idx_nxt;
      LT_ALL:  lt_pat_nxt = '1;
      default: lt_pat_nxt = '0;
    endcase
  end

  assign lamp_out = (lt_state != LT_IDLE) ? lt_pat : ch_lamp;
`else
  assign lamp_out = ch_lamp;
`endif

endmodule

// File: tb/tb_rpsc_annunciator_ctrl.sv
// Directed bench for rpsc_annunciator_ctrl (N_CH=8, FILT_CYC=4, FLASH_DIV=8, LT_STEP=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Lamp-test steps are included when RPSC_LAMP_TEST_EN is defined.
module tb_rpsc_annunciator_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] trip_in;
  logic       ack_btn;
  logic       rst_btn;
  logic       lamp_test_btn;
  logic [7:0] trip_latch_out;
  logic [7:0] lamp_out;
  logic       horn_out;
  logic       first_vld;
  logic [2:0] first_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rpsc_annunciator_ctrl #(
    .N_CH      (8),
    .FILT_CYC  (4),
    .FLASH_DIV (8)
`ifdef RPSC_LAMP_TEST_EN
    ,
    .LT_STEP   (16)
`endif
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trip_in        (trip_in),
    .ack_btn        (ack_btn),
    .rst_btn        (rst_btn),
`ifdef RPSC_LAMP_TEST_EN
    .lamp_test_btn  (lamp_test_btn),
`endif
    .trip_latch_out (trip_latch_out),
    .lamp_out       (lamp_out),
    .horn_out       (horn_out),
    .first_vld      (first_vld),
    .first_idx      (first_idx)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    trip_in       = 8'h00;
    ack_btn       = 1'b0;
    rst_btn       = 1'b0;
    lamp_test_btn = 1'b0;
    reset_n       = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_latch"}, 32'(trip_latch_out), 32'h0);
    check({tag, "_lamp"},  32'(lamp_out),       32'h0);
    check({tag, "_horn"},  32'(horn_out),       32'h0);
    check({tag, "_vld"},   32'(first_vld),      32'h0);
    check({tag, "_idx"},   32'(first_idx),      32'h0);
  endtask

  initial begin
    logic prev;
    int   last_chg;
    int   nchg;

    // Test 1: reset with all trips held high, then release.
    trip_in       = 8'hFF;
    ack_btn       = 1'b0;
    rst_btn       = 1'b0;
    lamp_test_btn = 1'b0;
    reset_n       = 1'b0;
    tick(3);
    check_all_zero("t1_in_reset");
    reset_n = 1'b1;
    tick(6);
    check("t1_latch_edge6", 32'(trip_latch_out), 32'h00);
    tick(1);
    check("t1_latch_edge7", 32'(trip_latch_out), 32'hFF);
    check("t1_horn",        32'(horn_out),       32'h1);
    check("t1_first_vld",   32'(first_vld),      32'h1);
    check("t1_first_idx",   32'(first_idx),      32'h0);

    // Test 2: a 3-cycle glitch is rejected, a held trip latches at edge 7 and flashes.
    do_reset();
    trip_in = 8'h08;
    tick(3);
    trip_in = 8'h00;
    tick(10);
    check("t2_glitch_latch", 32'(trip_latch_out), 32'h00);
    check("t2_glitch_vld",   32'(first_vld),      32'h0);
    trip_in = 8'h08;
    tick(6);
    check("t2_latch_edge6", 32'(trip_latch_out), 32'h00);
    tick(1);
    check("t2_latch_edge7", 32'(trip_latch_out), 32'h08);
    check("t2_horn",        32'(horn_out),       32'h1);
    check("t2_first_idx",   32'(first_idx),      32'h3);
    check("t2_first_vld",   32'(first_vld),      32'h1);
    prev     = lamp_out[3];
    last_chg = -1;
    nchg     = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      check("t2_other_lamps", 32'(lamp_out & 8'hF7), 32'h0);
      if (lamp_out[3] !== prev) begin
        if (last_chg >= 0) check("t2_flash_period", 32'(i - last_chg), 32'd8);
        last_chg = i;
        nchg++;
        prev = lamp_out[3];
      end
    end
    check("t2_flash_toggles", 32'(nchg >= 4), 32'h1);

    // Test 3: ack, rst with trip still present, then drop trip and rst.
    ack_btn = 1'b1;
    tick(4);
    check("t3_ack_lamp", 32'(lamp_out), 32'h08);
    check("t3_ack_horn", 32'(horn_out), 32'h0);
    ack_btn = 1'b0;
    tick(2);
    rst_btn = 1'b1;
    tick(5);
    check("t3_rst_held_latch", 32'(trip_latch_out), 32'h08);
    check("t3_rst_held_lamp",  32'(lamp_out),       32'h08);
    rst_btn = 1'b0;
    trip_in = 8'h00;
    tick(6);
    rst_btn = 1'b1;
    tick(3);
    check("t3_rst_latch",    32'(trip_latch_out), 32'h00);
    check("t3_rst_lamp",     32'(lamp_out),       32'h00);
    check("t3_vld_same_edge", 32'(first_vld),     32'h1);
    tick(1);
    check("t3_vld_next_edge", 32'(first_vld),     32'h0);
    check("t3_idx_next_edge", 32'(first_idx),     32'h0);
    rst_btn = 1'b0;

    // Test 4: simultaneous trips pick the lowest index; later trip keeps it; ack+rst in ALARM.
    do_reset();
    trip_in = 8'h24;
    tick(7);
    check("t4_latch",     32'(trip_latch_out), 32'h24);
    check("t4_first_idx", 32'(first_idx),      32'h2);
    check("t4_first_vld", 32'(first_vld),      32'h1);
    trip_in = 8'h25;
    tick(8);
    check("t4_latch_ch0",      32'(trip_latch_out), 32'h25);
    check("t4_first_idx_kept", 32'(first_idx),      32'h2);
    trip_in = 8'h00;
    tick(6);
    ack_btn = 1'b1;
    rst_btn = 1'b1;
    tick(4);
    check("t4_ackrst_latch", 32'(trip_latch_out), 32'h25);
    check("t4_ackrst_lamp",  32'(lamp_out),       32'h25);
    check("t4_ackrst_horn",  32'(horn_out),       32'h0);
    ack_btn = 1'b0;
    rst_btn = 1'b0;
    tick(2);
    rst_btn = 1'b1;
    tick(4);
    check("t4_cleared_latch", 32'(trip_latch_out), 32'h00);
    check("t4_cleared_vld",   32'(first_vld),      32'h0);
    rst_btn = 1'b0;

    // Test 5: one-cycle reset with ch1 ACKED and ch6 in ALARM.
    do_reset();
    trip_in = 8'h02;
    tick(8);
    ack_btn = 1'b1;
    tick(4);
    ack_btn = 1'b0;
    tick(2);
    trip_in = 8'h42;
    tick(8);
    check("t5_pre_latch",   32'(trip_latch_out), 32'h42);
    check("t5_pre_lamp1",   32'(lamp_out[1]),    32'h1);
    check("t5_pre_horn",    32'(horn_out),       32'h1);
    check("t5_pre_first",   32'(first_idx),      32'h1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check_all_zero("t5_reset");
    trip_in = 8'h00;
    tick(2);

`ifdef RPSC_LAMP_TEST_EN
    // Test 6: full lamp-test walk, then an abort by a new alarm.
    do_reset();
    lamp_test_btn = 1'b1;
    tick(3);
    for (int k = 0; k < 8; k++) begin
      check("t6_walk_first", 32'(lamp_out), 32'(8'h01 << k));
      tick(15);
      check("t6_walk_last",  32'(lamp_out), 32'(8'h01 << k));
      tick(1);
    end
    lamp_test_btn = 1'b0;
    check("t6_all_first", 32'(lamp_out), 32'hFF);
    tick(15);
    check("t6_all_last",  32'(lamp_out), 32'hFF);
    tick(1);
    check("t6_done",      32'(lamp_out), 32'h00);
    tick(4);
    lamp_test_btn = 1'b1;
    tick(3);
    check("t6_restart", 32'(lamp_out), 32'h01);
    tick(20);
    trip_in = 8'h10;
    tick(6);
    check("t6_before_abort", 32'(lamp_out), 32'h02);
    tick(1);
    check("t6_abort_others", 32'(lamp_out & 8'hEF), 32'h0);
    check("t6_abort_latch",  32'(trip_latch_out),   32'h10);
    check("t6_abort_horn",   32'(horn_out),         32'h1);
    prev = lamp_out[4];
    nchg = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (lamp_out[4] !== prev) nchg++;
      prev = lamp_out[4];
    end
    check("t6_abort_flash",  32'(nchg >= 2),         32'h1);
    check("t6_abort_after",  32'(lamp_out & 8'hEF), 32'h0);
    lamp_test_btn = 1'b0;
    trip_in = 8'h00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
